// File: rtl/ack_bus_sched.sv
// -----------------------------------------------------------------------------
// ack_bus_sched
//   Registered round-robin scheduler for the shared ACK bus. Four sources
//   (MEM=0, SHA=1, AES=2, CTRL=3) request the bus with level requests. Exactly
//   one source is granted at a time. The grant is held until that source
//   signals ack_done, drops its request, or exceeds TIMEOUT_CYCLES. One idle
//   (RELEASE) cycle always separates two grants.
//
// Ports
//   clk               rising-edge clock
//   rst               synchronous active-high reset
//   en                1 = new grants may be issued (a running grant ignores it)
//   req_mem/sha/aes/ctrl  level requests, sampled only while IDLE
//   ack_done          granted source releases the bus (used in GRANT only)
//   ack_ready_to_*    registered one-hot grant
//   winner_source_id  ID of the current / most recent winner
//   ack_event         1-cycle pulse in the first grant cycle
//   timeout_err       1-cycle pulse when a grant is forcibly revoked
//   busy              1 while the scheduler is in GRANT or RELEASE
// -----------------------------------------------------------------------------
module ack_bus_sched #(
    parameter int TIMEOUT_CYCLES = 15,
    parameter int CNT_W          = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       req_mem,
    input  logic       req_sha,
    input  logic       req_aes,
    input  logic       req_ctrl,
    input  logic       ack_done,
    output logic       ack_ready_to_mem,
    output logic       ack_ready_to_sha,
    output logic       ack_ready_to_aes,
    output logic       ack_ready_to_ctrl,
    output logic [1:0] winner_source_id,
    output logic       ack_event,
    output logic       timeout_err,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_GRANT   = 2'b01,
        ST_RELEASE = 2'b10
    } state_e;

    // Timeout compare value; only meaningful when the timeout is enabled.
    localparam bit               TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] TO_LAST = TO_EN ? CNT_W'(TIMEOUT_CYCLES - 1)
                                                 : {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Round-robin pick: first requester at offsets +1..+4 from the last
    // winner. Scanning downwards lets the nearest offset overwrite the others.
    // Result is {found, id}.
    function automatic logic [2:0] rr_pick(input logic [3:0] req,
                                           input logic [1:0] last);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int i = 4; i >= 1; i--) begin
            idx = last + 2'(i);
            if (req[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Binary ID to one-hot grant vector.
    function automatic logic [3:0] id_to_onehot(input logic [1:0] id);
        logic [3:0] oh;
        case (id)
            2'd0:    oh = 4'b0001;
            2'd1:    oh = 4'b0010;
            2'd2:    oh = 4'b0100;
            2'd3:    oh = 4'b1000;
            default: oh = 4'b0000;
        endcase
        return oh;
    endfunction

    state_e             state_q, state_d;
    logic [3:0]         grant_q, grant_d;
    logic [1:0]         winner_q, winner_d;
    logic               ack_event_q, ack_event_d;
    logic               timeout_err_q, timeout_err_d;
    logic               busy_q, busy_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         rr_q, rr_d;

    logic [3:0]         req_s;
    logic [2:0]         pick_s;
    logic               can_grant_s;
    logic               winner_req_s;
    logic               timeout_hit_s;

    assign req_s         = {req_ctrl, req_aes, req_sha, req_mem};
    assign pick_s        = rr_pick(req_s, rr_q);
    assign can_grant_s   = en & pick_s[2];
    assign winner_req_s  = req_s[winner_q];
    assign timeout_hit_s = TO_EN & (cnt_q == TO_LAST);

    // State and output registers; reset wins over every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            grant_q       <= 4'b0000;
            winner_q      <= 2'b00;
            ack_event_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            busy_q        <= 1'b0;
            cnt_q         <= {CNT_W{1'b0}};
            rr_q          <= 2'b11;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            winner_q      <= winner_d;
            ack_event_q   <= ack_event_d;
            timeout_err_q <= timeout_err_d;
            busy_q        <= busy_d;
            cnt_q         <= cnt_d;
            rr_q          <= rr_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (can_grant_s) begin
                    state_d = ST_GRANT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (ack_done || !winner_req_s || timeout_hit_s) begin
                    state_d = ST_RELEASE;
                end else begin
                    state_d = ST_GRANT;
                end
            end
            ST_RELEASE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs, counter and round-robin pointer.
    always_comb begin
        grant_d       = 4'b0000;
        winner_d      = winner_q;
        ack_event_d   = 1'b0;
        timeout_err_d = 1'b0;
        cnt_d         = cnt_q;
        rr_d          = rr_q;
        busy_d        = (state_d != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (can_grant_s) begin
                    grant_d     = id_to_onehot(pick_s[1:0]);
                    winner_d    = pick_s[1:0];
                    ack_event_d = 1'b1;
                    cnt_d       = {CNT_W{1'b0}};
                    rr_d        = pick_s[1:0];
                end else begin
                    cnt_d       = {CNT_W{1'b0}};
                end
            end
            ST_GRANT: begin
                // Exit priority: ack_done, then abandon, then timeout.
                if (ack_done) begin
                    grant_d = 4'b0000;
                end else if (!winner_req_s) begin
                    grant_d = 4'b0000;
                end else if (timeout_hit_s) begin
                    grant_d       = 4'b0000;
                    timeout_err_d = 1'b1;
                end else begin
                    grant_d = grant_q;
                    cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
                end
            end
            ST_RELEASE: begin
                grant_d = 4'b0000;
            end
            default: begin
                grant_d = 4'b0000;
            end
        endcase
    end

    assign ack_ready_to_mem  = grant_q[0];
    assign ack_ready_to_sha  = grant_q[1];
    assign ack_ready_to_aes  = grant_q[2];
    assign ack_ready_to_ctrl = grant_q[3];
    assign winner_source_id  = winner_q;
    assign ack_event         = ack_event_q;
    assign timeout_err       = timeout_err_q;
    assign busy              = busy_q;

endmodule

// File: tb/tb_ack_bus_sched.sv
// -----------------------------------------------------------------------------
// tb_ack_bus_sched
//   Directed bench for ack_bus_sched (TIMEOUT_CYCLES=15). Inputs change 1 ns
//   after a rising edge and outputs are sampled at the same point, so every
//   sample reflects the registers loaded at the preceding edge.
// -----------------------------------------------------------------------------
module tb_ack_bus_sched;

    logic       clk;
    logic       rst;
    logic       en;
    logic       req_mem, req_sha, req_aes, req_ctrl;
    logic       ack_done;
    logic       ack_ready_to_mem, ack_ready_to_sha, ack_ready_to_aes, ack_ready_to_ctrl;
    logic [1:0] winner_source_id;
    logic       ack_event;
    logic       timeout_err;
    logic       busy;
    logic [3:0] gnt_s;

    int n_checks = 0;
    int n_errors = 0;
    int held;

    ack_bus_sched #(.TIMEOUT_CYCLES(15), .CNT_W(4)) dut (
        .clk               (clk),
        .rst               (rst),
        .en                (en),
        .req_mem           (req_mem),
        .req_sha           (req_sha),
        .req_aes           (req_aes),
        .req_ctrl          (req_ctrl),
        .ack_done          (ack_done),
        .ack_ready_to_mem  (ack_ready_to_mem),
        .ack_ready_to_sha  (ack_ready_to_sha),
        .ack_ready_to_aes  (ack_ready_to_aes),
        .ack_ready_to_ctrl (ack_ready_to_ctrl),
        .winner_source_id  (winner_source_id),
        .ack_event         (ack_event),
        .timeout_err       (timeout_err),
        .busy              (busy)
    );

    assign gnt_s = {ack_ready_to_ctrl, ack_ready_to_aes, ack_ready_to_sha, ack_ready_to_mem};

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle; also checks the one-hot invariant.
    task automatic step();
        @(posedge clk);
        #1;
        check_eq("onehot", 32'($countones(gnt_s) <= 1), 32'd1);
    endtask

    task automatic expect_out(input string tag, input logic [3:0] g, input logic [1:0] id,
                              input logic ev, input logic to, input logic bz);
        check_eq({tag, ".gnt"},  32'(gnt_s), 32'(g));
        check_eq({tag, ".id"},   32'(winner_source_id), 32'(id));
        check_eq({tag, ".ev"},   32'(ack_event), 32'(ev));
        check_eq({tag, ".to"},   32'(timeout_err), 32'(to));
        check_eq({tag, ".busy"}, 32'(busy), 32'(bz));
    endtask

    task automatic set_req(input logic [3:0] r);
        {req_ctrl, req_aes, req_sha, req_mem} = r;
    endtask

    initial begin
        logic [1:0] exp_ids [5];
        exp_ids[0] = 2'd0; exp_ids[1] = 2'd1; exp_ids[2] = 2'd2;
        exp_ids[3] = 2'd3; exp_ids[4] = 2'd0;

        rst = 1'b1; en = 1'b0; ack_done = 1'b0;
        set_req(4'b0000);
        step(); step();
        rst = 1'b0;
        expect_out("reset", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);

        // 1: single SHA request, release by ack_done
        en = 1'b1; set_req(4'b0010);
        step();
        expect_out("t1.grant", 4'b0010, 2'd1, 1'b1, 1'b0, 1'b1);
        step();
        expect_out("t1.hold1", 4'b0010, 2'd1, 1'b0, 1'b0, 1'b1);
        step();
        expect_out("t1.hold2", 4'b0010, 2'd1, 1'b0, 1'b0, 1'b1);
        ack_done = 1'b1;
        step();
        expect_out("t1.release", 4'b0000, 2'd1, 1'b0, 1'b0, 1'b1);
        ack_done = 1'b0; set_req(4'b0000);
        step();
        expect_out("t1.idle", 4'b0000, 2'd1, 1'b0, 1'b0, 1'b0);

        // 2: all four requesting, rotation from reset pointer
        rst = 1'b1; step(); rst = 1'b0;
        set_req(4'b1111);
        for (int r = 0; r < 5; r++) begin
            step();
            expect_out($sformatf("t2.g%0d", r), 4'b0001 << exp_ids[r], exp_ids[r], 1'b1, 1'b0, 1'b1);
            ack_done = 1'b1;
            step();
            expect_out($sformatf("t2.rel%0d", r), 4'b0000, exp_ids[r], 1'b0, 1'b0, 1'b1);
            ack_done = 1'b0;
            step();
            expect_out($sformatf("t2.idle%0d", r), 4'b0000, exp_ids[r], 1'b0, 1'b0, 1'b0);
        end

        // 3: AES times out after 15 cycles, then CTRL wins
        set_req(4'b1100);
        step();
        expect_out("t3.grant", 4'b0100, 2'd2, 1'b1, 1'b0, 1'b1);
        held = 0;
        for (int i = 0; i < 40; i++) begin
            if (!ack_ready_to_aes) break;
            held++;
            step();
        end
        check_eq("t3.held", 32'(held), 32'd15);
        expect_out("t3.timeout", 4'b0000, 2'd2, 1'b0, 1'b1, 1'b1);
        step();
        expect_out("t3.after", 4'b0000, 2'd2, 1'b0, 1'b0, 1'b0);
        step();
        expect_out("t3.ctrl", 4'b1000, 2'd3, 1'b1, 1'b0, 1'b1);

        // 4b: winner abandons mid-grant
        step();
        set_req(4'b0100);
        step();
        expect_out("t4.abandon", 4'b0000, 2'd3, 1'b0, 1'b0, 1'b1);
        set_req(4'b0000);
        step();
        expect_out("t4.abidle", 4'b0000, 2'd3, 1'b0, 1'b0, 1'b0);

        // 4a: ack_done while counter is 14 beats the timeout
        rst = 1'b1; step(); rst = 1'b0;
        set_req(4'b0001);
        step();
        expect_out("t4.grant", 4'b0001, 2'd0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 14; i++) step();
        expect_out("t4.c14", 4'b0001, 2'd0, 1'b0, 1'b0, 1'b1);
        ack_done = 1'b1;
        step();
        expect_out("t4.donewins", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b1);
        ack_done = 1'b0; set_req(4'b0000);
        step();

        // 5: reset during CTRL grant, pointer returns to 11
        rst = 1'b1; step(); rst = 1'b0;
        set_req(4'b1000);
        step();
        expect_out("t5.ctrl", 4'b1000, 2'd3, 1'b1, 1'b0, 1'b1);
        step();
        rst = 1'b1;
        step();
        expect_out("t5.rst", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0; set_req(4'b1001);
        step();
        expect_out("t5.mem", 4'b0001, 2'd0, 1'b1, 1'b0, 1'b1);
        ack_done = 1'b1;
        step();
        ack_done = 1'b0; set_req(4'b0000);
        step();

        // 6: en gates new grants but not a running one
        en = 1'b0; set_req(4'b0100);
        for (int i = 0; i < 10; i++) begin
            step();
            check_eq("t6.nogrant", 32'(gnt_s), 32'd0);
            check_eq("t6.notbusy", 32'(busy), 32'd0);
        end
        en = 1'b1;
        step();
        expect_out("t6.grant", 4'b0100, 2'd2, 1'b1, 1'b0, 1'b1);
        en = 1'b0;
        step(); step();
        expect_out("t6.hold", 4'b0100, 2'd2, 1'b0, 1'b0, 1'b1);
        ack_done = 1'b1;
        step();
        expect_out("t6.release", 4'b0000, 2'd2, 1'b0, 1'b0, 1'b1);
        ack_done = 1'b0;
        step();
        expect_out("t6.idle", 4'b0000, 2'd2, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
